// File: rtl/seq_comp_sched.sv
// Round-robin scheduler sharing one bit-serial magnitude comparator between two
// requesters: per request it clears, loads, shifts N times, evaluates and responds.
module seq_comp_sched #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [2:0]   rsp_lgE,
    output logic         err,
    output logic         cmp_rst,
    output logic         cmp_load_A,
    output logic         cmp_load_B,
    output logic [N-1:0] cmp_in_A,
    output logic [N-1:0] cmp_in_B,
    output logic         cmp_op,
    input  logic         cmp_L,
    input  logic         cmp_E,
    input  logic         cmp_G
);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, EVAL, RESP} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     op_a, op_b;
    logic             id, last_grant, grant, accept;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lge;

    assign lge    = {cmp_L, cmp_E, cmp_G};
    assign accept = |(req_valid & req_ready);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11)
            grant = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CLR;
            CLR:     state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(N - 1)) state_nxt = EVAL;
            EVAL:    state_nxt = RESP;
            RESP:    if (rsp_ready[id]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        cmp_rst    = ~rst;
        cmp_load_A = 1'b0;
        cmp_load_B = 1'b0;
        cmp_in_A   = '0;
        cmp_in_B   = '0;
        cmp_op     = 1'b0;
        case (state)
            IDLE: if (rst && req_valid != 2'b00) req_ready = grant ? 2'b10 : 2'b01;
            CLR:  cmp_rst = 1'b1;
            LOAD: begin
                cmp_load_A = 1'b1;
                cmp_load_B = 1'b1;
                cmp_in_A   = op_a;
                cmp_in_B   = op_b;
            end
            EVAL: cmp_op = 1'b1;
            RESP: rsp_valid = id ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
            id         <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= '0;
            rsp_lgE    <= 3'b000;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= grant ? req1_a : req0_a;
                op_b       <= grant ? req1_b : req0_b;
                id         <= grant;
                last_grant <= grant;
            end
            if (state == LOAD)
                cnt <= '0;
            else if (state == SHIFT)
                cnt <= cnt + CNT_W'(1);
            if (state == EVAL) begin
                rsp_lgE <= lge;
                if (lge != 3'b100 && lge != 3'b010 && lge != 3'b001)
                    err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/seq_comp_sched.md
Name: seq_comp_sched

Overview:
Round-robin scheduler that shares one bit-serial magnitude comparator (seq_comp) between two requesters. It accepts operand pairs on valid/ready handshakes and sequences the comparator through reset, parallel load, N shift cycles and evaluation. It returns the one-hot {L,E,G} result to the requester that was granted. It sits between client logic and the seq_comp instance; seq_comp itself is unchanged.

Parameters:
N, 32, operand width; also the number of shift cycles the comparator needs after load.
CNT_W, $clog2(N+1), width of the shift counter. Derived; not overridden.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous reset, active-low: state is reset on a posedge clk while rst=0.
req_valid  in  2  per-requester operand-pair valid.
req_ready  out  2  per-requester accept; at most one bit high.
req0_a  in  N  requester 0 operand A.
req0_b  in  N  requester 0 operand B.
req1_a  in  N  requester 1 operand A.
req1_b  in  N  requester 1 operand B.
rsp_valid  out  2  one-hot result valid, addressed to the served requester.
rsp_ready  in  2  per-requester result accept.
rsp_lgE  out  3  result {L,E,G}; meaningful only while rsp_valid != 0.
err  out  1  sticky: set when the comparator returns {L,E,G} that is not one-hot.
cmp_rst  out  1  comparator reset, active-high.
cmp_load_A  out  1  comparator load_A.
cmp_load_B  out  1  comparator load_B.
cmp_in_A  out  N  comparator parallel_in_A.
cmp_in_B  out  N  comparator parallel_in_B.
cmp_op  out  1  comparator op (evaluate).
cmp_L  in  1  comparator L.
cmp_E  in  1  comparator E.
cmp_G  in  1  comparator G.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; last_grant=1, so requester 0 wins the first tie.
- Reset values: req_ready=0, rsp_valid=0, rsp_lgE=0, err=0, cmp_load_A/B=0, cmp_op=0, cmp_in_A/B=0.
- cmp_rst = (rst==0) | (state==CLR). Combinational, so the comparator is held in reset whenever the scheduler is in reset.
- FSM states: IDLE, CLR, LOAD, SHIFT, EVAL, RESP.
- IDLE:
  - grant = round-robin winner among req_valid; the non-last_grant requester has priority when both are valid.
  - req_ready[grant]=1, combinational from req_valid and last_grant.
  - On req_valid[g] & req_ready[g]: latch that requester's a/b into opA/opB, store id=g, last_grant<=g, go to CLR.
- CLR: 1 cycle, cmp_rst=1 -> LOAD.
- LOAD: 1 cycle, cmp_load_A=cmp_load_B=1, cmp_in_A=opA, cmp_in_B=opB; cnt<=0 -> SHIFT.
- SHIFT: cnt increments each cycle; after exactly N cycles (cnt==N-1) -> EVAL.
- EVAL: 1 cycle, cmp_op=1.
  - At the posedge, latch rsp_lgE<={cmp_L,cmp_E,cmp_G}.
  - If {L,E,G} is not one-hot, set err<=1.
  - -> RESP.
- RESP:
  - rsp_valid[id]=1; rsp_lgE held stable.
  - On rsp_ready[id] -> IDLE, rsp_valid<=0.
  - rsp_ready of the other requester is ignored.
  - No new grant until IDLE.
- Latency: accept cycle -> rsp_valid high N+3 posedges later (CLR+LOAD+N SHIFT+EVAL). For N=32 this is 35.
- Throughput: minimum N+5 cycles per request, counting 1 RESP and 1 IDLE cycle.
- Back-to-back: a requester holding req_valid high is re-granted only if the other is idle.
- Simultaneous first request after reset: requester 0 is served, then requester 1.
- cmp_in_A/B equal opA/opB only in LOAD; they are 0 otherwise.
- Reset mid-operation (any state): next state IDLE, all outputs return to reset values, the in-flight request is dropped, err clears.
- req_valid deasserting while not granted: no effect. Operands are sampled only at accept.

Test Plan:
- req_valid=01, req0 a=456 b=123, rsp_ready held 1 -> cmp_op pulses at cycle 34 after accept; rsp_valid=01 at cycle 35 with rsp_lgE=001 (G); err=0.
- req_valid=10, req1 a=123 b=123 -> rsp_valid=10, rsp_lgE=010 (E); next request is granted 2 cycles after the response handshake.
- Both valid from reset: req0 (12,123) and req1 (123,12) -> first response rsp_valid=01, lgE=100; second rsp_valid=10, lgE=001; then a third both-valid round grants req0 again (alternation).
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_lgE stable; req_ready=00; no cmp_load pulse until the handshake completes.
- rst=0 for 1 cycle during SHIFT (cycle 10) -> next cycle all outputs 0 and cmp_rst=1; a fresh req0 (7,7) then completes with E after N+3 cycles.
- Comparator stub drives L=1,G=1 during EVAL -> err=1 and stays 1 across later good responses until rst=0.
